// File: rtl/pwm_spi_pkg.sv
// rtl/pwm_spi_pkg.sv - shared state encoding and command field positions
package pwm_spi_pkg;

  typedef enum logic [2:0] {
    CMD     = 3'd0,
    ADDR_LO = 3'd1,
    WDATA   = 3'd2,
    RDATA   = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  localparam int CMD_WR_BIT    = 7;
  localparam int CMD_BURST_BIT = 6;

endpackage

// File: rtl/burst_addr_ctr.sv
// rtl/burst_addr_ctr.sv - burst address register with wrap and transfer count
module burst_addr_ctr #(
  parameter int ADDR_W    = 6,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] cur,
  output logic              burst_last,
  output logic              burst_done
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] count;

  // load and step together mean the first transfer happens at base in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      count <= '0;
    end else if (clear) begin
      cur   <= '0;
      count <= '0;
    end else if (load || step) begin
      cur   <= (load ? base : cur) + ADDR_W'(step);
      count <= (load ? '0 : count) + CNT_W'(step);
    end
  end

  assign burst_last = (count == CNT_W'(MAX_BURST - 1));
  assign burst_done = (count == CNT_W'(MAX_BURST));

endmodule

// File: rtl/instr_dcd_burst.sv
// rtl/instr_dcd_burst.sv - SPI command decoder with optional address byte and bursts
module instr_dcd_burst
  import pwm_spi_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_sync,
  input  logic              frame_end,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
  output logic              busy
);

  state_t            state, nxt;
  logic              cmd_wr, cmd_burst;
  logic [5:0]        cmd_hi;
  logic              ctr_load, ctr_step, rd_fire, wr_fire;
  logic              burst_last, burst_done;
  logic [ADDR_W-1:0] base, cur, strobe_addr;

  // Wide addresses keep only the low command bits above the address byte
  assign base = (ADDR_W > 6) ? ADDR_W'({cmd_hi, data_in}) : ADDR_W'(data_in[5:0]);

  always_comb begin
    nxt      = state;
    ctr_load = 1'b0;
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    case (state)
      CMD: if (byte_sync) begin
        if (ADDR_W > 6) begin
          nxt = ADDR_LO;
        end else begin
          ctr_load = 1'b1;
          if (data_in[CMD_WR_BIT]) nxt = WDATA;
          else begin
            nxt     = RDATA;
            rd_fire = 1'b1;
          end
        end
      end
      ADDR_LO: if (byte_sync) begin
        ctr_load = 1'b1;
        if (cmd_wr) nxt = WDATA;
        else begin
          nxt     = RDATA;
          rd_fire = 1'b1;
        end
      end
      WDATA: if (byte_sync) begin
        wr_fire = 1'b1;
        if (!cmd_burst || burst_last) nxt = IGNORE;
      end
      RDATA: if (byte_sync) begin
        if (!cmd_burst || burst_done) nxt = IGNORE;
        else rd_fire = 1'b1;
      end
      IGNORE: nxt = IGNORE;
      default: nxt = CMD;
    endcase
    if (frame_end) nxt = CMD;
    ctr_step    = rd_fire | wr_fire;
    strobe_addr = ctr_load ? base : cur;
  end

  burst_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (frame_end),
    .load       (ctr_load),
    .step       (ctr_step),
    .base       (base),
    .cur        (cur),
    .burst_last (burst_last),
    .burst_done (burst_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CMD;
      busy       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      data_write <= 8'h00;
      data_out   <= 8'h00;
      cmd_wr     <= 1'b0;
      cmd_burst  <= 1'b0;
      cmd_hi     <= 6'h00;
    end else begin
      state <= nxt;
      busy  <= (nxt != CMD);
      read  <= rd_fire;
      write <= wr_fire;
      if (rd_fire || wr_fire) addr <= strobe_addr;
      if (wr_fire) data_write <= data_in;
      if (read) data_out <= data_read;
      if (state == CMD && byte_sync) begin
        cmd_wr    <= data_in[CMD_WR_BIT];
        cmd_burst <= data_in[CMD_BURST_BIT];
        cmd_hi    <= data_in[5:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_dcd_burst.sv
// tb/tb_instr_dcd_burst.sv - scoreboard bench, two decoder configurations in parallel
module tb_instr_dcd_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic       frame_end = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout_a, dout_b, dw_a, dw_b, drd_a, drd_b;
  logic       rd_a, wr_a, busy_a, rd_b, wr_b, busy_b;
  logic [5:0] addr_a;
  logic [9:0] addr_b;

  always #5 clk = ~clk;

  // Register bank returns address + 0x10
  assign drd_a = {2'b00, addr_a} + 8'h10;
  assign drd_b = addr_b[7:0] + 8'h10;

  instr_dcd_burst #(.ADDR_W(6), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .byte_sync(byte_sync), .frame_end(frame_end),
    .data_in(data_in), .data_out(dout_a), .read(rd_a), .write(wr_a),
    .addr(addr_a), .data_read(drd_a), .data_write(dw_a), .busy(busy_a)
  );

  instr_dcd_burst #(.ADDR_W(10), .MAX_BURST(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .byte_sync(byte_sync), .frame_end(frame_end),
    .data_in(data_in), .data_out(dout_b), .read(rd_b), .write(wr_b),
    .addr(addr_b), .data_read(drd_b), .data_write(dw_b), .busy(busy_b)
  );

  typedef struct {
    bit wr;
    int addr;
    int data;
  } ev_t;

  ev_t        qa[$];
  ev_t        qb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         sync_cyc = -10;
  bit         pend[2];
  int         pend_val[2];
  logic [7:0] fb[0:15];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic mon(int d, logic rd, logic wr, int a, int dw, int dout);
    ev_t e;
    bit  empty;
    if (pend[d]) begin
      chk($sformatf("dut%0d data_out", d), dout, pend_val[d]);
      pend[d] = 1'b0;
    end
    if (rd || wr) begin
      chk($sformatf("dut%0d rd_wr_exclusive", d), int'(rd & wr), 0);
      empty = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected strobe: got rd=%0d wr=%0d addr=0x%0h expected none",
                 d, rd, wr, a);
      end else begin
        if (d == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk($sformatf("dut%0d strobe_kind", d), int'(wr), int'(e.wr));
        chk($sformatf("dut%0d addr", d), a, e.addr);
        chk($sformatf("dut%0d strobe_latency", d), cyc - sync_cyc, 1);
        if (wr) chk($sformatf("dut%0d data_write", d), dw, e.data);
        else begin
          pend[d]     = 1'b1;
          pend_val[d] = e.data;
        end
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_sync) sync_cyc = cyc;
    mon(0, rd_a, wr_a, int'(addr_a), int'(dw_a), int'(dout_a));
    mon(1, rd_b, wr_b, int'(addr_b), int'(dw_b), int'(dout_b));
  end

  // Reference: the transfers a frame of n bytes should produce for one configuration
  task automatic model(int d, int aw, int mb, int n);
    int         base, idx, nd, cnt, m;
    logic [7:0] b0;
    ev_t        e;
    if (n == 0) return;
    b0 = fb[0];
    m  = 1 << aw;
    if (aw > 6) begin
      if (n < 2) return;
      base = (int'(b0[5:0]) * 256 + int'(fb[1])) % m;
      idx  = 2;
    end else begin
      base = int'(b0[5:0]);
      idx  = 1;
    end
    nd = n - idx;
    if (b0[7]) cnt = b0[6] ? imin(nd, mb) : imin(nd, 1);
    else       cnt = b0[6] ? imin(nd + 1, mb) : 1;
    for (int k = 0; k < cnt; k++) begin
      e.wr   = b0[7];
      e.addr = (base + k) % m;
      e.data = b0[7] ? int'(fb[idx + k]) : (e.addr + 16) % 256;
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b, bit fe);
    byte_sync = 1'b1;
    data_in   = b;
    frame_end = fe;
    tick(1);
    byte_sync = 1'b0;
    frame_end = 1'b0;
    tick(3);
  endtask

  task automatic run_frame(int n, bit fe_last);
    model(0, 6, 4, n);
    model(1, 10, 16, n);
    for (int i = 0; i < n; i++) send_byte(fb[i], fe_last && (i == n - 1));
    if (!(fe_last && n > 0)) begin
      chk("busy_a in frame", int'(busy_a), int'(n > 0));
      chk("busy_b in frame", int'(busy_b), int'(n > 0));
      frame_end = 1'b1;
      tick(1);
      frame_end = 1'b0;
    end
    tick(2);
    chk("busy_a after frame", int'(busy_a), 0);
    chk("busy_b after frame", int'(busy_b), 0);
    chk("qa drained", qa.size(), 0);
    chk("qb drained", qb.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst read_a", int'(rd_a), 0);
    chk("rst write_a", int'(wr_a), 0);
    chk("rst busy_a", int'(busy_a), 0);
    chk("rst addr_a", int'(addr_a), 0);
    chk("rst data_write_a", int'(dw_a), 0);
    chk("rst data_out_a", int'(dout_a), 0);
    chk("rst busy_b", int'(busy_b), 0);
    chk("rst addr_b", int'(addr_b), 0);
    chk("rst data_write_b", int'(dw_b), 0);
    chk("rst data_out_b", int'(dout_b), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick(3);
    chk_reset_outputs();
    rst_n = 1'b1;
    tick(2);

    fb[0] = 8'h85; fb[1] = 8'h3C; fb[2] = 8'h11;
    run_frame(3, 1'b0);

    fb[0] = 8'h7E; fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03;
    run_frame(4, 1'b0);

    fb[0] = 8'hC2; fb[1] = 8'h7F; fb[2] = 8'h01; fb[3] = 8'h02; fb[4] = 8'h03;
    run_frame(5, 1'b0);

    fb[0] = 8'hC0;
    for (int i = 1; i < 7; i++) fb[i] = 8'(8'hA0 + i);
    run_frame(7, 1'b0);

    fb[0] = 8'h81;
    run_frame(1, 1'b0);

    fb[0] = 8'h7E; fb[1] = 8'h20; fb[2] = 8'h55;
    run_frame(3, 1'b1);

    // Abort by reset while a write burst is waiting for its next byte
    fb[0] = 8'hC0; fb[1] = 8'h11;
    model(0, 6, 4, 2);
    model(1, 10, 16, 2);
    send_byte(fb[0], 1'b0);
    send_byte(fb[1], 1'b0);
    rst_n = 1'b0;
    tick(1);
    chk_reset_outputs();
    rst_n = 1'b1;
    tick(1);
    chk("qa after reset", qa.size(), 0);
    chk("qb after reset", qb.size(), 0);

    fb[0] = 8'h83; fb[1] = 8'h5A; fb[2] = 8'hE7;
    run_frame(3, 1'b0);

    repeat (40) begin
      int n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      run_frame(n, 1'($urandom_range(0, 1)));
    end

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
